// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Scan controller for a 4-digit multiplexed seven-segment display.
//   A frame (4 hex nibbles plus a decimal-point mask) is written through a
//   valid/ready handshake into a shadow buffer. It is copied to the active
//   buffer only at a frame boundary, so a scan never shows a mix of two frames.
//   Each digit slot starts with a blanking gap (all anodes off) to suppress
//   ghosting, followed by the lit period. All pins are active-low and registered.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous reset, active-low
//   wr_valid   frame write request
//   wr_ready   high while the shadow buffer is free
//   wr_data    digit nibbles, [3:0] = digit0 (an[0], rightmost) .. [15:12] = digit3
//   wr_dp      decimal-point enable per digit, 1 = lit
//   an         anode enables, active-low
//   seg        segments {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low
//   frame_done one-cycle pulse after the last lit cycle of digit3
//
// FSM states
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_BLANK | all anodes off for BLANK_CNT cycles (skipped when 0)
//   ST_SHOW  | anode of the current digit on for REFRESH_CNT cycles
module seg_scan_ctrl #(
    parameter int unsigned REFRESH_CNT = 65000,
    parameter int unsigned BLANK_CNT   = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_dp,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    localparam bit          SKIP_BLANK = (BLANK_CNT == 0);
    localparam logic [15:0] SHOW_LAST  = 16'(REFRESH_CNT - 1);
    localparam logic [15:0] BLANK_LAST = SKIP_BLANK ? 16'd0 : 16'(BLANK_CNT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  digit_q, digit_d;
    logic [15:0] act_data_q, act_data_d;
    logic [3:0]  act_dp_q, act_dp_d;
    logic [15:0] sh_data_q, sh_data_d;
    logic [3:0]  sh_dp_q, sh_dp_d;
    logic        pending_q, pending_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic        done_q, done_d;
    logic        boundary;
    logic        accept;
    logic [3:0]  nibble;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        s = 7'h7F;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 16'd1;
        digit_d    = digit_q;
        boundary   = 1'b0;
        act_data_d = act_data_q;
        act_dp_d   = act_dp_q;
        sh_data_d  = sh_data_q;
        sh_dp_d    = sh_dp_q;
        pending_d  = pending_q;
        an_d       = 4'hF;
        seg_d      = 7'h7F;
        dp_d       = 1'b1;
        nibble     = 4'h0;

        case (state_q)
            ST_BLANK: begin
                if (SKIP_BLANK || cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = 16'd0;
                end
            end
            ST_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    cnt_d    = 16'd0;
                    digit_d  = digit_q + 2'd1;
                    boundary = (digit_q == 2'd3);
                    state_d  = SKIP_BLANK ? ST_SHOW : ST_BLANK;
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = 16'd0;
            end
        endcase

        // Transfer and acceptance are mutually exclusive: acceptance needs
        // pending low, transfer needs it high. A write landing on the boundary
        // cycle therefore waits a whole frame for the next boundary.
        accept = wr_valid && !pending_q;
        if (boundary && pending_q) begin
            act_data_d = sh_data_q;
            act_dp_d   = sh_dp_q;
            pending_d  = 1'b0;
        end
        if (accept) begin
            sh_data_d = wr_data;
            sh_dp_d   = wr_dp;
            pending_d = 1'b1;
        end

        // Pins are computed from the next state and the next active frame so
        // that an, seg and dp change together, including on the transfer edge
        // when no blanking gap separates digit3 from digit0.
        if (state_d == ST_SHOW) begin
            nibble = act_data_d[{digit_d, 2'b00} +: 4];
            an_d   = ~(4'b0001 << digit_d);
            seg_d  = seg_decode(nibble);
            dp_d   = ~act_dp_d[digit_d];
        end

        done_d = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BLANK;
            cnt_q      <= 16'd0;
            digit_q    <= 2'd0;
            act_data_q <= 16'd0;
            act_dp_q   <= 4'd0;
            sh_data_q  <= 16'd0;
            sh_dp_q    <= 4'd0;
            pending_q  <= 1'b0;
            an_q       <= 4'hF;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            digit_q    <= digit_d;
            act_data_q <= act_data_d;
            act_dp_q   <= act_dp_d;
            sh_data_q  <= sh_data_d;
            sh_dp_q    <= sh_dp_d;
            pending_q  <= pending_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            done_q     <= done_d;
        end
    end

    assign wr_ready   = ~pending_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = done_q;

endmodule
